// File: rtl/riscv.sv
// Single-cycle RV64I subset core (ADD/SUB/AND/OR/XOR, OP-IMM, LD/SD, BEQ/BNE) driving external IMEM/DMEM/RF.
// Define RISCV_MUL_EN to decode MUL (low 64 bits of rs1*rs2); otherwise that encoding is a no-op.
module riscv #(
    parameter int unsigned XLEN     = 64,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            inst,
    output logic [XLEN-1:0]        PC_IMEM,
    input  logic [XLEN-1:0]        readData_DMEM,
    output logic [XLEN-1:0]        addrData_DMEM,
    output logic [XLEN-1:0]        wrData_DMEM,
    output logic                   MemWrite_DMEM,
    output logic                   MemRead_DMEM,
    input  logic signed [XLEN-1:0] readData1_RF,
    input  logic signed [XLEN-1:0] readData2_RF,
    output logic [4:0]             readAddr1_RF,
    output logic [4:0]             readAddr2_RF,
    output logic [XLEN-1:0]        writeData_RF,
    output logic [4:0]             writeAddr_RF,
    output logic                   RegWrite_RF
);

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OPIMM  = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011
    } opcode_e;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] immediate;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] alu_result;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            reg_write;
    logic            mem_write;
    logic            mem_read;
    logic            is_load;
    logic            branch_taken;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rs1    = readData1_RF;
    assign rs2    = readData2_RF;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    always_comb begin
        immediate = '0;
        case (opcode)
            OPC_OPIMM,
            OPC_LOAD:   immediate = {{(XLEN-12){inst[31]}}, inst[31:20]};
            OPC_STORE:  immediate = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH: immediate = {{(XLEN-13){inst[31]}}, inst[31], inst[7],
                                     inst[30:25], inst[11:8], 1'b0};
            default:    immediate = '0;
        endcase
    end

    always_comb begin
        alu_result   = '0;
        reg_write    = 1'b0;
        mem_write    = 1'b0;
        is_load      = 1'b0;
        branch_taken = 1'b0;
        case (opcode)
            OPC_OP: begin
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: begin alu_result = rs1 + rs2; reg_write = 1'b1; end
                    {7'b0100000, 3'b000}: begin alu_result = rs1 - rs2; reg_write = 1'b1; end
                    {7'b0000000, 3'b111}: begin alu_result = rs1 & rs2; reg_write = 1'b1; end
                    {7'b0000000, 3'b110}: begin alu_result = rs1 | rs2; reg_write = 1'b1; end
                    {7'b0000000, 3'b100}: begin alu_result = rs1 ^ rs2; reg_write = 1'b1; end
`ifdef RISCV_MUL_EN
                    {7'b0000001, 3'b000}: begin alu_result = rs1 * rs2; reg_write = 1'b1; end
`endif
                    default: ;
                endcase
            end
            OPC_OPIMM: begin
                case (funct3)
                    3'b000:  begin alu_result = rs1 + immediate; reg_write = 1'b1; end
                    3'b100:  begin alu_result = rs1 ^ immediate; reg_write = 1'b1; end
                    3'b110:  begin alu_result = rs1 | immediate; reg_write = 1'b1; end
                    3'b111:  begin alu_result = rs1 & immediate; reg_write = 1'b1; end
                    default: ;
                endcase
            end
            OPC_LOAD: begin
                if (funct3 == 3'b011) begin
                    is_load   = 1'b1;
                    reg_write = 1'b1;
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b011) begin
                    mem_write = 1'b1;
                end
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  branch_taken = (rs1 == rs2);
                    3'b001:  branch_taken = (rs1 != rs2);
                    default: ;
                endcase
            end
            default: ;
        endcase
        // Reset suppresses every side effect; the decode itself stays free-running
        mem_read = is_load && !rst;
        if (rst) begin
            reg_write = 1'b0;
            mem_write = 1'b0;
        end
    end

    assign next_pc = branch_taken ? (pc + immediate) : (pc + 64'd4);

    assign PC_IMEM       = pc;
    assign addrData_DMEM = rs1 + immediate;
    assign wrData_DMEM   = rs2;
    assign MemWrite_DMEM = mem_write;
    assign MemRead_DMEM  = mem_read;
    assign readAddr1_RF  = inst[19:15];
    assign readAddr2_RF  = inst[24:20];
    assign writeAddr_RF  = inst[11:7];
    assign writeData_RF  = is_load ? readData_DMEM : alu_result;
    assign RegWrite_RF   = reg_write;

endmodule

// File: tb/tb_riscv.sv
// Directed bench for riscv: models IMEM, DMEM and register file around the core.
module tb_riscv;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        inst;
    logic [63:0]        PC_IMEM;
    logic [63:0]        readData_DMEM;
    logic [63:0]        addrData_DMEM;
    logic [63:0]        wrData_DMEM;
    logic               MemWrite_DMEM;
    logic               MemRead_DMEM;
    logic signed [63:0] readData1_RF;
    logic signed [63:0] readData2_RF;
    logic [4:0]         readAddr1_RF;
    logic [4:0]         readAddr2_RF;
    logic [63:0]        writeData_RF;
    logic [4:0]         writeAddr_RF;
    logic               RegWrite_RF;

    int unsigned errors = 0;
    int unsigned checks = 0;

    localparam logic [63:0] SENT = 64'hDEAD_BEEF_CAFE_F00D;

    logic [31:0] imem [0:31];
    logic [63:0] dmem [0:15];
    logic [63:0] rf   [0:31];

    riscv #(.XLEN(64), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst(rst), .inst(inst), .PC_IMEM(PC_IMEM),
        .readData_DMEM(readData_DMEM), .addrData_DMEM(addrData_DMEM),
        .wrData_DMEM(wrData_DMEM), .MemWrite_DMEM(MemWrite_DMEM),
        .MemRead_DMEM(MemRead_DMEM), .readData1_RF(readData1_RF),
        .readData2_RF(readData2_RF), .readAddr1_RF(readAddr1_RF),
        .readAddr2_RF(readAddr2_RF), .writeData_RF(writeData_RF),
        .writeAddr_RF(writeAddr_RF), .RegWrite_RF(RegWrite_RF)
    );

    always #5 clk = ~clk;

    assign inst          = imem[PC_IMEM[6:2]];
    assign readData_DMEM = dmem[addrData_DMEM[6:3]];
    assign readData1_RF  = (readAddr1_RF == 5'd0) ? 64'sd0 : rf[readAddr1_RF];
    assign readData2_RF  = (readAddr2_RF == 5'd0) ? 64'sd0 : rf[readAddr2_RF];

    always @(posedge clk) begin
        if (RegWrite_RF && writeAddr_RF != 5'd0) rf[writeAddr_RF] <= writeData_RF;
        if (MemWrite_DMEM) dmem[addrData_DMEM[6:3]] <= wrData_DMEM;
    end

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic no_side_effects(input string tag);
        check({tag, ".regwrite"}, {63'd0, RegWrite_RF}, 64'd0);
        check({tag, ".memwrite"}, {63'd0, MemWrite_DMEM}, 64'd0);
        check({tag, ".memread"},  {63'd0, MemRead_DMEM}, 64'd0);
    endtask

    task automatic expect_wb(input string tag, input logic [63:0] pc, input logic [63:0] val);
        check({tag, ".pc"}, PC_IMEM, pc);
        check({tag, ".regwrite"}, {63'd0, RegWrite_RF}, 64'd1);
        check({tag, ".wdata"}, writeData_RF, val);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) imem[i] = 32'h0;
        for (int i = 0; i < 16; i++) dmem[i] = 64'h0;
        for (int i = 0; i < 32; i++) rf[i] = SENT;
        imem[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);     // ADDI x1,x0,5
        imem[1]  = enc_i(12'd3, 5'd0, 3'b000, 5'd2, 7'b0010011);     // ADDI x2,x0,3
        imem[2]  = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);      // ADD x3
        imem[3]  = enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd4);      // SUB x4
        imem[4]  = enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd5);      // AND x5
        imem[5]  = enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd6);      // OR x6
        imem[6]  = enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd7);      // MUL x7
        imem[7]  = enc_s(12'd0, 5'd3, 5'd0);                         // SD x3,0(x0)
        imem[8]  = enc_i(12'd0, 5'd0, 3'b011, 5'd8, 7'b0000011);     // LD x8,0(x0)
        imem[9]  = enc_b(13'd8, 5'd8, 5'd3, 3'b000);                 // BEQ x3,x8,+8
        imem[10] = enc_i(12'd123, 5'd0, 3'b000, 5'd9, 7'b0010011);   // skipped
        imem[11] = enc_b(13'd8, 5'd4, 5'd3, 3'b001);                 // BNE x3,x4,+8
        imem[12] = enc_i(12'd77, 5'd0, 3'b000, 5'd10, 7'b0010011);   // skipped
        imem[13] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd11);     // XOR x11
        imem[14] = enc_i(12'd8, 5'd1, 3'b110, 5'd12, 7'b0010011);    // ORI x12,x1,8
        imem[15] = 32'h0000_0000;                                    // unrecognised
        imem[16] = enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, 7'b0010011);   // ADDI x1,x0,-1
        imem[17] = enc_b(13'd0, 5'd0, 5'd0, 3'b000);                 // halt

        rst = 1'b1;
        @(negedge clk);
        check("rst1.pc", PC_IMEM, 64'h0);
        no_side_effects("rst1");
        @(negedge clk);
        check("rst2.pc", PC_IMEM, 64'h0);
        no_side_effects("rst2");
        rst = 1'b0;
        #1;
        expect_wb("addi5", 64'd0, 64'd5);
        check("addi5.imm", dut.immediate, 64'd5);
        check("addi5.rd", {59'd0, writeAddr_RF}, 64'd1);
        @(negedge clk); expect_wb("addi3", 64'd4, 64'd3);
        @(negedge clk); expect_wb("add", 64'd8, 64'd8);
        check("add.ra1", {59'd0, readAddr1_RF}, 64'd1);
        check("add.ra2", {59'd0, readAddr2_RF}, 64'd2);
        @(negedge clk); expect_wb("sub", 64'd12, 64'd2);
        @(negedge clk); expect_wb("and", 64'd16, 64'd1);
        @(negedge clk); expect_wb("or", 64'd20, 64'd7);
        @(negedge clk);
`ifdef RISCV_MUL_EN
        expect_wb("mul", 64'd24, 64'd15);
`else
        check("mul.pc", PC_IMEM, 64'd24);
        no_side_effects("mul");
`endif
        @(negedge clk);
        check("sd.pc", PC_IMEM, 64'd28);
        check("sd.memwrite", {63'd0, MemWrite_DMEM}, 64'd1);
        check("sd.regwrite", {63'd0, RegWrite_RF}, 64'd0);
        check("sd.addr", addrData_DMEM, 64'd0);
        check("sd.data", wrData_DMEM, 64'd8);
        @(negedge clk);
        check("ld.memread", {63'd0, MemRead_DMEM}, 64'd1);
        expect_wb("ld", 64'd32, 64'd8);
        @(negedge clk);
        check("beq.pc", PC_IMEM, 64'd36);
        check("beq.imm", dut.immediate, 64'd8);
        no_side_effects("beq");
        @(negedge clk);
        check("bne.pc", PC_IMEM, 64'd44);
        check("bne.imm", dut.immediate, 64'd8);
        no_side_effects("bne");
        @(negedge clk); expect_wb("xor", 64'd52, 64'd6);
        @(negedge clk); expect_wb("ori", 64'd56, 64'd13);
        @(negedge clk);
        check("bad.pc", PC_IMEM, 64'd60);
        no_side_effects("bad");
        @(negedge clk);
        expect_wb("addim1", 64'd64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addim1.imm", dut.immediate, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check("halt.pc", PC_IMEM, 64'd68);
            check("halt.wr", {62'd0, RegWrite_RF, MemWrite_DMEM}, 64'd0);
        end
        check("rf.x1", rf[1], 64'hFFFF_FFFF_FFFF_FFFF);
        check("rf.x2", rf[2], 64'd3);
        check("rf.x3", rf[3], 64'd8);
        check("rf.x4", rf[4], 64'd2);
        check("rf.x5", rf[5], 64'd1);
        check("rf.x6", rf[6], 64'd7);
`ifdef RISCV_MUL_EN
        check("rf.x7", rf[7], 64'd15);
`else
        check("rf.x7", rf[7], SENT);
`endif
        check("rf.x8", rf[8], 64'd8);
        check("rf.x9", rf[9], SENT);
        check("rf.x10", rf[10], SENT);
        check("rf.x11", rf[11], 64'd6);
        check("rf.x12", rf[12], 64'd13);
        check("dmem0", dmem[0], 64'd8);

        // Mid-program reset: PC returns to 0 and the ADDI there must not retire while rst holds
        rst = 1'b1;
        @(negedge clk);
        check("rst3.pc", PC_IMEM, 64'h0);
        no_side_effects("rst3");
        @(negedge clk);
        check("rst4.pc", PC_IMEM, 64'h0);
        check("rst4.x1", rf[1], 64'hFFFF_FFFF_FFFF_FFFF);
        rst = 1'b0;
        @(negedge clk);
        check("rel.pc", PC_IMEM, 64'd4);
        check("rel.x1", rf[1], 64'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
